// File: rtl/input_vc_scheduler.sv
// input_vc_scheduler: per-VC IDLE/VA/ACTIVE control with credit-gated read arbitration.
// ROUND_ROBIN_EN selects round-robin read arbitration; the default build is fixed priority.
package input_vc_scheduler_pkg;
  typedef enum logic [1:0] {HEAD, BODY, TAIL} flit_label_t;
endpackage

module input_vc_scheduler
  import input_vc_scheduler_pkg::*;
#(
  parameter int VC_NUM = 2,
  parameter int BUFFER_SIZE = 8,
  localparam int VC_SIZE = VC_NUM > 1 ? $clog2(VC_NUM) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [VC_NUM-1:0]              is_empty_i,
  input  flit_label_t [VC_NUM-1:0]       flit_label_i,
  output logic [VC_NUM-1:0]              va_req_o,
  input  logic [VC_NUM-1:0]              va_grant_i,
  input  logic [VC_NUM-1:0][VC_SIZE-1:0] va_vc_i,
  output logic [VC_NUM-1:0]              vc_valid_o,
  output logic [VC_NUM-1:0][VC_SIZE-1:0] vc_new_o,
  input  logic [VC_NUM-1:0]              credit_i,
  output logic [VC_NUM-1:0]              read_o,
  output logic                           err_o
);
  typedef enum logic [1:0] {IDLE, VA, ACTIVE} state_t;
  localparam int CW = $clog2(BUFFER_SIZE + 1);
  localparam logic [CW-1:0] FULL = CW'(BUFFER_SIZE);
  state_t [VC_NUM-1:0] state_q, state_d;
  logic [VC_NUM-1:0][CW-1:0] credit_q, credit_d;
  logic [VC_NUM-1:0] elig, dec;
  logic err_d;
  always_comb begin
    for (int v = 0; v < VC_NUM; v++) begin
      va_req_o[v] = state_q[v] == VA;
      elig[v] = state_q[v] == ACTIVE && !is_empty_i[v] && !vc_valid_o[v] && credit_q[vc_new_o[v]] != '0;
    end
  end
`ifdef ROUND_ROBIN_EN
  logic [VC_SIZE-1:0] ptr_q, gnt;
  // scan downward so the candidate closest to ptr_q is written last and wins
  always_comb begin
    read_o = '0;
    gnt = '0;
    for (int i = VC_NUM - 1; i >= 0; i--)
      if (elig[(int'(ptr_q) + i) % VC_NUM]) begin
        read_o = '0;
        read_o[(int'(ptr_q) + i) % VC_NUM] = 1'b1;
        gnt = VC_SIZE'((int'(ptr_q) + i) % VC_NUM);
      end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) ptr_q <= '0;
    else if (|read_o) ptr_q <= VC_SIZE'((int'(gnt) + 1) % VC_NUM);
`else
  assign read_o = elig & -elig;
`endif
  always_comb begin
    state_d = state_q;
    err_d = err_o;
    dec = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      if (read_o[v]) dec[vc_new_o[v]] = 1'b1;
      if (va_grant_i[v] && state_q[v] != VA) err_d = 1'b1;
      if (state_q[v] == IDLE && !is_empty_i[v]) begin
        if (flit_label_i[v] == HEAD) state_d[v] = VA;
        else err_d = 1'b1;
      end
      if (state_q[v] == VA && va_grant_i[v]) state_d[v] = ACTIVE;
      if (read_o[v] && flit_label_i[v] == TAIL) state_d[v] = IDLE;
    end
    // a read and a returning credit on the same downstream VC cancel out
    for (int d = 0; d < VC_NUM; d++) begin
      credit_d[d] = credit_i[d] && !dec[d] ? (credit_q[d] == FULL ? FULL : credit_q[d] + CW'(1)) :
                    !credit_i[d] && dec[d] ? credit_q[d] - CW'(1) : credit_q[d];
      if (credit_i[d] && !dec[d] && credit_q[d] == FULL) err_d = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int v = 0; v < VC_NUM; v++) begin
        state_q[v] <= IDLE;
        credit_q[v] <= FULL;
      end
      vc_valid_o <= '0;
      vc_new_o <= '0;
      err_o <= 1'b0;
    end else begin
      state_q <= state_d;
      credit_q <= credit_d;
      err_o <= err_d;
      for (int v = 0; v < VC_NUM; v++) begin
        vc_valid_o[v] <= state_q[v] == VA && va_grant_i[v];
        if (state_q[v] == VA && va_grant_i[v]) vc_new_o[v] <= va_vc_i[v];
      end
    end
  end
endmodule

// File: tb/tb_input_vc_scheduler.sv
// tb_input_vc_scheduler: table-driven packet, corner sequences and random traffic against a reference model.
module tb_input_vc_scheduler;
  import input_vc_scheduler_pkg::*;
  localparam int VC_NUM = 2;
  localparam int BS = 8;
  localparam int VC_SIZE = 1;
`ifdef ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [VC_NUM-1:0] is_empty, va_grant, credit;
  flit_label_t [VC_NUM-1:0] label;
  logic [VC_NUM-1:0][VC_SIZE-1:0] va_vc;
  logic [VC_NUM-1:0] va_req, vc_valid, read;
  logic [VC_NUM-1:0][VC_SIZE-1:0] vc_new;
  logic err;
  int passed = 0;
  int total = 0;
  int m_st[VC_NUM];
  int m_cr[VC_NUM];
  int m_vc[VC_NUM];
  bit m_vld[VC_NUM];
  bit m_err;
  int m_rr;
  flit_label_t q[VC_NUM][$];
  logic [VC_NUM-1:0] last_rd;

  typedef struct {
    logic [1:0] g, vc, req, vld, rd, nw;
  } row_t;
  row_t tbl[9];

  input_vc_scheduler #(.VC_NUM(VC_NUM), .BUFFER_SIZE(BS)) dut (
    .clk(clk), .rst(rst), .is_empty_i(is_empty), .flit_label_i(label),
    .va_req_o(va_req), .va_grant_i(va_grant), .va_vc_i(va_vc),
    .vc_valid_o(vc_valid), .vc_new_o(vc_new), .credit_i(credit),
    .read_o(read), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else passed++;
  endtask

  function automatic void m_reset();
    for (int v = 0; v < VC_NUM; v++) begin
      m_st[v] = 0;
      m_cr[v] = BS;
      m_vc[v] = 0;
      m_vld[v] = 1'b0;
    end
    m_err = 1'b0;
    m_rr = 0;
  endfunction

  // states: 0 idle, 1 waiting for allocation, 2 active
  function automatic logic [VC_NUM-1:0] m_read();
    for (int k = 0; k < VC_NUM; k++) begin
      int v;
      v = RR ? (m_rr + k) % VC_NUM : k;
      if (m_st[v] == 2 && !is_empty[v] && !m_vld[v] && m_cr[m_vc[v]] > 0) return VC_NUM'(1) << v;
    end
    return '0;
  endfunction

  function automatic void m_step(input logic [VC_NUM-1:0] r);
    int used[VC_NUM];
    for (int d = 0; d < VC_NUM; d++) used[d] = 0;
    for (int v = 0; v < VC_NUM; v++)
      if (r[v]) begin
        used[m_vc[v]]++;
        m_rr = (v + 1) % VC_NUM;
      end
    for (int d = 0; d < VC_NUM; d++) begin
      if (credit[d] && used[d] == 0 && m_cr[d] == BS) m_err = 1'b1;
      else m_cr[d] += int'(credit[d]) - used[d];
    end
    for (int v = 0; v < VC_NUM; v++) begin
      if (va_grant[v] && m_st[v] != 1) m_err = 1'b1;
      m_vld[v] = 1'b0;
      if (m_st[v] == 0 && !is_empty[v]) begin
        if (label[v] == HEAD) m_st[v] = 1;
        else m_err = 1'b1;
      end else if (m_st[v] == 1 && va_grant[v]) begin
        m_st[v] = 2;
        m_vc[v] = int'(va_vc[v]);
        m_vld[v] = 1'b1;
      end else if (m_st[v] == 2 && r[v] && label[v] == TAIL) m_st[v] = 0;
    end
  endfunction

  task automatic drive_q();
    for (int v = 0; v < VC_NUM; v++) begin
      is_empty[v] = q[v].size() == 0;
      label[v] = q[v].size() == 0 ? HEAD : q[v][0];
    end
  endtask

  task automatic push_pkt(input int v, input int len);
    q[v].push_back(HEAD);
    for (int i = 0; i < len - 2; i++) q[v].push_back(BODY);
    q[v].push_back(TAIL);
  endtask

  task automatic tick();
    logic [VC_NUM-1:0] r, req, vld;
    #1;
    r = m_read();
    for (int v = 0; v < VC_NUM; v++) begin
      req[v] = m_st[v] == 1;
      vld[v] = m_vld[v];
      check("vc_new_o", int'(vc_new[v]), m_vc[v]);
    end
    check("read_o", int'(read), int'(r));
    check("va_req_o", int'(va_req), int'(req));
    check("vc_valid_o", int'(vc_valid), int'(vld));
    check("err_o", int'(err), int'(m_err));
    last_rd = read;
    m_step(r);
    @(posedge clk);
    for (int v = 0; v < VC_NUM; v++) if (r[v]) void'(q[v].pop_front());
    @(negedge clk);
    va_grant = '0;
    credit = '0;
    drive_q();
  endtask

  task automatic reset_dut(input bit keep);
    rst = 1'b0;
    if (!keep) for (int v = 0; v < VC_NUM; v++) q[v].delete();
    m_reset();
    drive_q();
    #1;
    check("rst_read", int'(read), 0);
    check("rst_req", int'(va_req), 0);
    check("rst_valid", int'(vc_valid), 0);
    check("rst_new", int'(vc_new), 0);
    check("rst_err", int'(err), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int n;
    logic [VC_NUM-1:0] got[4];
    logic [VC_NUM-1:0] exp_rd[4];
    tbl = '{
      '{2'd0, 2'd0, 2'b00, 2'b00, 2'b00, 2'd0},
      '{2'd0, 2'd0, 2'b01, 2'b00, 2'b00, 2'd0},
      '{2'd1, 2'd1, 2'b01, 2'b00, 2'b00, 2'd0},
      '{2'd0, 2'd0, 2'b00, 2'b01, 2'b00, 2'd1},
      '{2'd0, 2'd0, 2'b00, 2'b00, 2'b01, 2'd1},
      '{2'd0, 2'd0, 2'b00, 2'b00, 2'b01, 2'd1},
      '{2'd0, 2'd0, 2'b00, 2'b00, 2'b01, 2'd1},
      '{2'd0, 2'd0, 2'b00, 2'b00, 2'b01, 2'd1},
      '{2'd0, 2'd0, 2'b00, 2'b00, 2'b00, 2'd1}
    };
    va_grant = '0;
    credit = '0;
    va_vc = '0;
    drive_q();
    @(negedge clk);
    reset_dut(1'b0);
    // single HEAD/BODY/BODY/TAIL packet on VC0, allocated downstream VC1
    push_pkt(0, 4);
    drive_q();
    for (int i = 0; i < 9; i++) begin
      va_grant = tbl[i].g;
      va_vc[0] = tbl[i].vc[VC_SIZE-1:0];
      #1;
      check("tbl_req", int'(va_req), int'(tbl[i].req));
      check("tbl_valid", int'(vc_valid), int'(tbl[i].vld));
      check("tbl_read", int'(read), int'(tbl[i].rd));
      check("tbl_new0", int'(vc_new[0]), int'(tbl[i].nw));
      tick();
    end
    // downstream VC1 now holds 4 credits: a 6-flit packet stalls after 4 reads
    push_pkt(0, 6);
    drive_q();
    tick();
    va_grant = 2'b01;
    va_vc[0] = 1'b1;
    tick();
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n += int'(last_rd[0]);
    end
    check("exhaust_reads", n, 4);
    credit = 2'b10;
    tick();
    n = int'(last_rd[0]);
    for (int i = 0; i < 5; i++) begin
      tick();
      n += int'(last_rd[0]);
    end
    check("one_credit_one_read", n, 1);
    // both VCs active at once
    reset_dut(1'b0);
    push_pkt(0, 4);
    push_pkt(1, 4);
    drive_q();
    tick();
    va_grant = 2'b11;
    va_vc[0] = 1'b0;
    va_vc[1] = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      got[i] = last_rd;
      exp_rd[i] = RR && i % 2 == 1 ? 2'b10 : 2'b01;
    end
    for (int i = 0; i < 4; i++) check("arb_order", int'(got[i]), int'(exp_rd[i]));
    // read and credit in the same cycle leave the counter unchanged
    reset_dut(1'b0);
    push_pkt(0, 4);
    drive_q();
    tick();
    va_grant = 2'b01;
    va_vc[0] = 1'b0;
    tick();
    tick();
    tick();
    credit = 2'b01;
    tick();
    check("read_with_credit", int'(last_rd), 1);
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      credit = 2'b01;
      tick();
    end
    check("err_before_overflow", int'(err), 0);
    credit = 2'b01;
    tick();
    check("err_overflow", int'(err), 1);
    // reset mid-packet leaves BODY at head-of-queue
    reset_dut(1'b0);
    push_pkt(0, 4);
    drive_q();
    tick();
    va_grant = 2'b01;
    va_vc[0] = 1'b1;
    tick();
    tick();
    tick();
    tick();
    reset_dut(1'b1);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n += $countones(last_rd);
    end
    check("no_read_after_rst", n, 0);
    check("err_after_body", int'(err), 1);
    // random legal traffic
    reset_dut(1'b0);
    for (int c = 0; c < 800; c++) begin
      for (int v = 0; v < VC_NUM; v++)
        if (q[v].size() == 0 && $urandom_range(3) == 0) push_pkt(v, int'($urandom_range(5, 2)));
      drive_q();
      for (int v = 0; v < VC_NUM; v++)
        if (m_st[v] == 1 && $urandom_range(2) == 0) begin
          va_grant[v] = 1'b1;
          va_vc[v] = VC_SIZE'($urandom_range(VC_NUM - 1));
        end
      for (int d = 0; d < VC_NUM; d++) credit[d] = m_cr[d] < BS && $urandom_range(2) == 0;
      tick();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
